// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared geometry defaults for the instruction cache slice.
package inst_cache_pkg;
    localparam int DEF_WORD_SIZE   = 32;
    localparam int DEF_BLOCK_SIZE  = 16;
    localparam int DEF_NUM_LINES   = 8;
    localparam int DEF_MEM_LATENCY = 2;
endpackage

// File: rtl/inst_cache_line_array.sv
// inst_cache_line_array: valid/tag/data storage with a combinational read port and one-cycle block write.
module inst_cache_line_array
    import inst_cache_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int OFF_W      = $clog2(BLOCK_SIZE),
    parameter int TAG_W      = WORD_SIZE - OFF_W - IDX_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IDX_W-1:0]              rd_idx,
    input  logic [OFF_W-1:0]              rd_off,
    output logic [WORD_SIZE-1:0]          rd_word,
    output logic [TAG_W-1:0]              rd_tag,
    output logic                          rd_valid,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] wr_block,
    input  logic                          clear
);
    logic [NUM_LINES-1:0]            valid;
    logic [TAG_W-1:0]                tags [NUM_LINES];
    logic [WORD_SIZE*BLOCK_SIZE-1:0] data [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (clear)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_block;
        end
    end

    // word 0 of a block sits in the MSBs
    assign rd_word  = data[rd_idx][WORD_SIZE*(BLOCK_SIZE-int'(rd_off))-1 -: WORD_SIZE];
    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache; zero-latency hits, fixed-latency block fills on miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WORD_SIZE-1:0]            pc,
    input  logic                            req,
    input  logic                            flush,
    output logic [WORD_SIZE-1:0]            inst,
    output logic                            inst_valid,
    output logic                            stall,
    output logic [WORD_SIZE-1:0]            mem_ptr,
    output logic                            mem_req,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block,
    output logic [31:0]                     miss_count
);
    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic {ST_LOOKUP, ST_FILL} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit, miss_start, last, fill_done;

    inst_cache_line_array #(
        .WORD_SIZE (WORD_SIZE),
        .BLOCK_SIZE(BLOCK_SIZE),
        .NUM_LINES (NUM_LINES)
    ) u_lines (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (pc[OFF_W +: IDX_W]),
        .rd_off  (pc[OFF_W-1:0]),
        .rd_word (inst),
        .rd_tag  (rd_tag),
        .rd_valid(rd_valid),
        .wr_en   (fill_done),
        .wr_idx  (mem_ptr[OFF_W +: IDX_W]),
        .wr_tag  (mem_ptr[WORD_SIZE-1 -: TAG_W]),
        .wr_block(mem_block),
        .clear   (flush)
    );

    assign hit = rd_valid && (rd_tag == pc[WORD_SIZE-1 -: TAG_W]);

    always_comb begin
        last       = (state == ST_FILL) && (cnt == CNT_W'(1));
        miss_start = (state == ST_LOOKUP) && req && !hit && !flush;
        fill_done  = last && !flush;
        inst_valid = (state == ST_LOOKUP) && req && hit;
        stall      = (state == ST_FILL) || (req && !hit);
        state_nx   = (state == ST_LOOKUP) ? (miss_start ? ST_FILL : ST_LOOKUP)
                                          : ((flush || last) ? ST_LOOKUP : ST_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOOKUP;
            cnt        <= '0;
            mem_ptr    <= '0;
            mem_req    <= 1'b0;
            miss_count <= '0;
        end else begin
            state <= state_nx;
            if (miss_start) begin
                mem_ptr    <= {pc[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                mem_req    <= 1'b1;
                cnt        <= CNT_W'(MEM_LATENCY);
                miss_count <= miss_count + 32'd1;
            end else if (state == ST_FILL) begin
                cnt <= cnt - 1'b1;
                if (flush || last)
                    mem_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed self-checking bench for inst_cache (default build and a MEM_LATENCY=1 build).
module tb_inst_cache;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  pc = '0, pc1 = '0;
    logic         req = 1'b0, req1 = 1'b0, flush = 1'b0, flush1 = 1'b0;
    logic [31:0]  inst, inst1, mem_ptr, mem_ptr1, miss_count, miss_count1;
    logic         inst_valid, inst_valid1, stall, stall1, mem_req, mem_req1;
    logic [511:0] mem_block, mem_block1;
    int           n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    // memory word at address a is 0xDEAD0000 | a; garbage when no fill is active
    function automatic logic [511:0] blk(input logic [31:0] p, input logic en);
        logic [511:0] b;
        for (int k = 0; k < 16; k++)
            b[32*(16-k)-1 -: 32] = en ? (32'hDEAD0000 | (p + 32'(k))) : 32'hBAD0BAD0;
        return b;
    endfunction

    assign mem_block  = blk(mem_ptr, mem_req);
    assign mem_block1 = blk(mem_ptr1, mem_req1);

    inst_cache u_dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .req(req), .flush(flush),
        .inst(inst), .inst_valid(inst_valid), .stall(stall),
        .mem_ptr(mem_ptr), .mem_req(mem_req), .mem_block(mem_block),
        .miss_count(miss_count)
    );

    inst_cache #(.MEM_LATENCY(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .pc(pc1), .req(req1), .flush(flush1),
        .inst(inst1), .inst_valid(inst_valid1), .stall(stall1),
        .mem_ptr(mem_ptr1), .mem_req(mem_req1), .mem_block(mem_block1),
        .miss_count(miss_count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] cnt_exp);
        tick(); pc = a; req = 1'b1; flush = 1'b0; #1;
        chk("miss_stall", 32'(stall), 32'd1);
        chk("miss_no_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("fill1_mem_req", 32'(mem_req), 32'd1);
        chk("fill1_mem_ptr", mem_ptr, {a[31:4], 4'h0});
        chk("fill1_miss_count", miss_count, cnt_exp);
        chk("fill1_stall", 32'(stall), 32'd1);
        tick();
        chk("fill2_mem_req", 32'(mem_req), 32'd1);
        chk("fill2_stall", 32'(stall), 32'd1);
        tick();
        chk("post_fill_valid", 32'(inst_valid), 32'd1);
        chk("post_fill_inst", inst, 32'hDEAD0000 | a);
        chk("post_fill_stall", 32'(stall), 32'd0);
        chk("post_fill_mem_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_ptr", mem_ptr, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        #10 rst_n = 1'b1;

        // cold miss then sequential hits over the block
        do_miss(32'h25, 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick(); pc = 32'h20 + 32'(i); #1;
            chk("seq_valid", 32'(inst_valid), 32'd1);
            chk("seq_inst", inst, 32'hDEAD0020 + 32'(i));
            chk("seq_stall", 32'(stall), 32'd0);
        end
        chk("seq_miss_count", miss_count, 32'd1);

        // conflict on index 2
        do_miss(32'hA5, 32'd2);
        do_miss(32'h25, 32'd3);
        chk("conflict_miss_count", miss_count, 32'd3);

        // flush in the second fill cycle aborts the fill
        tick(); pc = 32'h45; req = 1'b1; #1;
        chk("fl_miss_stall", 32'(stall), 32'd1);
        tick();
        chk("fl_fill1_req", 32'(mem_req), 32'd1);
        tick(); flush = 1'b1; #1;
        chk("fl_fill2_req", 32'(mem_req), 32'd1);
        tick(); flush = 1'b0; req = 1'b0; #1;
        chk("fl_abort_req", 32'(mem_req), 32'd0);
        chk("fl_abort_stall", 32'(stall), 32'd0);
        chk("fl_miss_count", miss_count, 32'd4);
        tick(); pc = 32'h45; req = 1'b1; #1;
        chk("fl_line_invalid", 32'(stall), 32'd1);
        req = 1'b0;
        do_miss(32'h25, 32'd5);

        // flush on a hit still serves it; flush on a miss starts no fill
        tick(); pc = 32'h25; req = 1'b1; flush = 1'b1; #1;
        chk("flhit_valid", 32'(inst_valid), 32'd1);
        chk("flhit_inst", inst, 32'hDEAD0025);
        tick(); #1;
        chk("flmiss_stall", 32'(stall), 32'd1);
        chk("flmiss_valid", 32'(inst_valid), 32'd0);
        tick(); flush = 1'b0; req = 1'b0; #1;
        chk("flmiss_no_req", 32'(mem_req), 32'd0);
        chk("flmiss_count", miss_count, 32'd5);

        // async reset in the middle of a fill
        tick(); pc = 32'h25; req = 1'b1; #1;
        tick();
        chk("ar_fill_req", 32'(mem_req), 32'd1);
        chk("ar_miss_count", miss_count, 32'd6);
        #2 rst_n = 1'b0; #1;
        chk("ar_mem_req", 32'(mem_req), 32'd0);
        chk("ar_mem_ptr", mem_ptr, 32'd0);
        chk("ar_miss_count0", miss_count, 32'd0);
        req = 1'b0;
        tick(); rst_n = 1'b1;
        do_miss(32'h25, 32'd1);

        // MEM_LATENCY=1 build: two stall cycles, word 0 from the MSBs
        tick(); pc1 = 32'h30; req1 = 1'b1; #1;
        chk("l1_stall0", 32'(stall1), 32'd1);
        tick();
        chk("l1_stall1", 32'(stall1), 32'd1);
        chk("l1_mem_req", 32'(mem_req1), 32'd1);
        chk("l1_mem_ptr", mem_ptr1, 32'h30);
        tick();
        chk("l1_stall2", 32'(stall1), 32'd0);
        chk("l1_valid", 32'(inst_valid1), 32'd1);
        chk("l1_inst_msb_word", inst1, 32'hDEAD0030);
        chk("l1_miss_count", miss_count1, 32'd1);
        tick(); pc1 = 32'h3F; #1;
        chk("l1_inst_lsb_word", inst1, 32'hDEAD003F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
